// File: rtl/hazard_detection_unit_if.sv
// Hazard unit interface: operands from the pipeline stages in,
// stall/flush/bubble controls and performance counters out.
interface hazard_detection_unit_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           ID_read_register_0;
    logic [4:0]           ID_read_register_1;
    logic                 ID_uses_register_0;
    logic                 ID_uses_register_1;
    logic                 EX_mem_read;
    logic [4:0]           EX_destination_register;
    logic                 EX_branch_taken;
    logic                 MEM_mem_request;
    logic                 MEM_mem_ready;
    logic                 PC_write_enable;
    logic                 IF_ID_write_enable;
    logic                 IF_ID_flush;
    logic                 ID_EX_write_enable;
    logic                 ID_EX_bubble;
    logic                 EX_MEM_write_enable;
    logic                 MEM_WB_bubble;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] flush_count;
    logic                 mem_timeout_error;

    modport master (
        output ID_read_register_0, ID_read_register_1,
        output ID_uses_register_0, ID_uses_register_1,
        output EX_mem_read, EX_destination_register,
        output EX_branch_taken, MEM_mem_request, MEM_mem_ready,
        input  PC_write_enable, IF_ID_write_enable, IF_ID_flush,
        input  ID_EX_write_enable, ID_EX_bubble,
        input  EX_MEM_write_enable, MEM_WB_bubble,
        input  stall_cycles, flush_count, mem_timeout_error
    );

    modport slave (
        input  ID_read_register_0, ID_read_register_1,
        input  ID_uses_register_0, ID_uses_register_1,
        input  EX_mem_read, EX_destination_register,
        input  EX_branch_taken, MEM_mem_request, MEM_mem_ready,
        output PC_write_enable, IF_ID_write_enable, IF_ID_flush,
        output ID_EX_write_enable, ID_EX_bubble,
        output EX_MEM_write_enable, MEM_WB_bubble,
        output stall_cycles, flush_count, mem_timeout_error
    );
endinterface

// File: rtl/hazard_detection_unit.sv
// Hazard detection for the 5-stage RV32I pipeline: load-use stalls,
// taken-branch flushes, data-memory freezes and perf counters.
module hazard_detection_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255,
    parameter int CNT_WIDTH         = 32
) (
    input logic clk,
    input logic reset,
    hazard_detection_unit_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LOAD_USE = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0]  REM_INIT = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [15:0] TIMEOUT  = 16'(MEM_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t      state, state_nx;
    state_t      saved_state, saved_nx;
    logic [1:0]  remaining, rem_nx;
    logic [1:0]  saved_rem, srem_nx;
    logic [15:0] wait_cnt, cnt_nx;
    logic        timeout_hit;

    logic [CNT_WIDTH-1:0] stall_q, flush_q;
    logic                 error_q;

    logic pc_we, ifid_we, ifid_flush, idex_we;
    logic idex_bubble, exmem_we, memwb_bubble;

    logic   load_use, mem_wait, rs1_hit, rs2_hit;
    state_t eff_state;
    logic [1:0] eff_rem;

    assign rs1_hit = hz.ID_uses_register_0 &&
                     (hz.ID_read_register_0 == hz.EX_destination_register);
    assign rs2_hit = hz.ID_uses_register_1 &&
                     (hz.ID_read_register_1 == hz.EX_destination_register);
    assign load_use = hz.EX_mem_read &&
                      (hz.EX_destination_register != 5'd0) &&
                      (rs1_hit || rs2_hit);
    assign mem_wait = hz.MEM_mem_request && !hz.MEM_mem_ready;

    // leaving a wait resumes the interrupted state within the same cycle
    assign eff_state = (state == MEM_WAIT) ? saved_state : state;
    assign eff_rem   = (state == MEM_WAIT) ? saved_rem : remaining;

    // next state and pipeline controls, freeze > flush > stall > run
    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_we     = 1'b1;
        memwb_bubble = 1'b0;
        state_nx     = RUN;
        rem_nx       = remaining;
        saved_nx     = saved_state;
        srem_nx      = saved_rem;
        cnt_nx       = wait_cnt;
        timeout_hit  = 1'b0;
        if (mem_wait) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
            state_nx     = MEM_WAIT;
            if (state == MEM_WAIT) begin
                if (wait_cnt != 16'hFFFF) cnt_nx = wait_cnt + 16'd1;
            end else begin
                saved_nx = state;
                srem_nx  = remaining;
                cnt_nx   = 16'd1;
            end
            timeout_hit = (cnt_nx >= TIMEOUT);
        end else if (hz.EX_branch_taken) begin
            // the stalled ID instruction is wrong-path; drop its stall
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            rem_nx      = 2'd0;
        end else if (eff_state == LOAD_USE) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            if (eff_rem > 2'd1) begin
                state_nx = LOAD_USE;
                rem_nx   = eff_rem - 2'd1;
            end else begin
                rem_nx   = 2'd0;
            end
        end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_nx = LOAD_USE;
                rem_nx   = REM_INIT;
            end
        end
        if (reset) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            ifid_flush   = 1'b1;
            idex_we      = 1'b0;
            idex_bubble  = 1'b1;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
        end
    end

    // state, saved context and wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            saved_state <= RUN;
            remaining   <= 2'd0;
            saved_rem   <= 2'd0;
            wait_cnt    <= 16'd0;
        end else begin
            state       <= state_nx;
            saved_state <= saved_nx;
            remaining   <= rem_nx;
            saved_rem   <= srem_nx;
            wait_cnt    <= cnt_nx;
        end
    end

    // saturating perf counters and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (!pc_we && stall_q != '1) stall_q <= stall_q + CNT_ONE;
            if (ifid_flush && flush_q != '1) flush_q <= flush_q + CNT_ONE;
            if (timeout_hit) error_q <= 1'b1;
        end
    end

    assign hz.PC_write_enable     = pc_we;
    assign hz.IF_ID_write_enable  = ifid_we;
    assign hz.IF_ID_flush         = ifid_flush;
    assign hz.ID_EX_write_enable  = idex_we;
    assign hz.ID_EX_bubble        = idex_bubble;
    assign hz.EX_MEM_write_enable = exmem_we;
    assign hz.MEM_WB_bubble       = memwb_bubble;
    assign hz.stall_cycles        = stall_q;
    assign hz.flush_count         = flush_q;
    assign hz.mem_timeout_error   = error_q;
endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench: unit A (1 bubble, default timeout) and
// unit B (3 bubbles, timeout 3) share clock and reset.
module tb_hazard_detection_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    // control word {PC_we, IFID_we, IFID_flush, IDEX_we, IDEX_bubble, EXMEM_we, MEMWB_bubble}
    localparam logic [31:0] NORM   = 32'b1101010;
    localparam logic [31:0] STALL  = 32'b0001110;
    localparam logic [31:0] FLUSH  = 32'b1111110;
    localparam logic [31:0] FREEZE = 32'b0000001;
    localparam logic [31:0] RSTV   = 32'b0010101;

    always #5 clk = ~clk;

    hazard_detection_unit_if #(.CNT_WIDTH(32)) a_if ();
    hazard_detection_unit_if #(.CNT_WIDTH(32)) b_if ();

    hazard_detection_unit #(
        .LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(255), .CNT_WIDTH(32)
    ) dut_a (.clk(clk), .reset(reset), .hz(a_if.slave));

    hazard_detection_unit #(
        .LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(3), .CNT_WIDTH(32)
    ) dut_b (.clk(clk), .reset(reset), .hz(b_if.slave));

    function automatic logic [31:0] ctl_a();
        return {25'd0, a_if.PC_write_enable, a_if.IF_ID_write_enable,
                a_if.IF_ID_flush, a_if.ID_EX_write_enable, a_if.ID_EX_bubble,
                a_if.EX_MEM_write_enable, a_if.MEM_WB_bubble};
    endfunction

    function automatic logic [31:0] ctl_b();
        return {25'd0, b_if.PC_write_enable, b_if.IF_ID_write_enable,
                b_if.IF_ID_flush, b_if.ID_EX_write_enable, b_if.ID_EX_bubble,
                b_if.EX_MEM_write_enable, b_if.MEM_WB_bubble};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic [4:0] r0, input logic [4:0] r1,
                           input logic u0, input logic u1, input logic mr,
                           input logic [4:0] rd, input logic br,
                           input logic req, input logic rdy);
        a_if.ID_read_register_0 = r0;
        a_if.ID_read_register_1 = r1;
        a_if.ID_uses_register_0 = u0;
        a_if.ID_uses_register_1 = u1;
        a_if.EX_mem_read = mr;
        a_if.EX_destination_register = rd;
        a_if.EX_branch_taken = br;
        a_if.MEM_mem_request = req;
        a_if.MEM_mem_ready = rdy;
    endtask

    task automatic drive_b(input logic [4:0] r0, input logic [4:0] r1,
                           input logic u0, input logic u1, input logic mr,
                           input logic [4:0] rd, input logic br,
                           input logic req, input logic rdy);
        b_if.ID_read_register_0 = r0;
        b_if.ID_read_register_1 = r1;
        b_if.ID_uses_register_0 = u0;
        b_if.ID_uses_register_1 = u1;
        b_if.EX_mem_read = mr;
        b_if.EX_destination_register = rd;
        b_if.EX_branch_taken = br;
        b_if.MEM_mem_request = req;
        b_if.MEM_mem_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_ctl_a", ctl_a(), RSTV);
        chk("rst_stall_a", a_if.stall_cycles, 0);
        chk("rst_flush_a", a_if.flush_count, 0);
        chk("rst_err_b", 32'(b_if.mem_timeout_error), 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("run_ctl_a", ctl_a(), NORM);
        chk("run_ctl_b", ctl_b(), NORM);

        // T1: lw x5 in EX, add reads x5
        drive_a(5, 6, 1, 1, 1, 5, 0, 0, 0);
        #1;
        chk("t1_stall", ctl_a(), STALL);
        tick();
        drive_a(5, 6, 1, 1, 0, 0, 0, 0, 0);
        #1;
        chk("t1_resume", ctl_a(), NORM);
        chk("t1_cnt", a_if.stall_cycles, 1);

        // T3: x0 destination and unqualified rs1 never stall
        drive_a(0, 0, 1, 1, 1, 0, 0, 0, 0);
        #1;
        chk("t3_x0", ctl_a(), NORM);
        drive_a(5, 7, 0, 1, 1, 5, 0, 0, 0);
        #1;
        chk("t3_unused", ctl_a(), NORM);
        drive_a(7, 5, 0, 1, 1, 5, 0, 0, 0);
        #1;
        chk("t3_rs2", ctl_a(), STALL);
        tick();
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t3_cnt", a_if.stall_cycles, 2);

        // T4: branch wins over load-use
        drive_a(5, 6, 1, 1, 1, 5, 1, 0, 0);
        #1;
        chk("t4_flush", ctl_a(), FLUSH);
        tick();
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t4_after", ctl_a(), NORM);
        chk("t4_fcnt", a_if.flush_count, 1);
        chk("t4_scnt", a_if.stall_cycles, 2);

        // T2: three-bubble load-use on unit B
        drive_b(5, 6, 1, 1, 1, 5, 0, 0, 0);
        #1;
        chk("t2_s1", ctl_b(), STALL);
        tick();
        drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t2_s2", ctl_b(), STALL);
        tick();
        chk("t2_s3", ctl_b(), STALL);
        tick();
        chk("t2_run", ctl_b(), NORM);
        chk("t2_cnt", b_if.stall_cycles, 3);

        // T5: four-cycle freeze inside LOAD_USE with remaining=2
        drive_b(5, 6, 1, 1, 1, 5, 0, 0, 0);
        #1;
        chk("t5_s1", ctl_b(), STALL);
        tick();
        drive_b(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t5_frz%0d", i), ctl_b(), FREEZE);
            tick();
        end
        drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t5_s2", ctl_b(), STALL);
        tick();
        chk("t5_s3", ctl_b(), STALL);
        tick();
        chk("t5_run", ctl_b(), NORM);
        chk("t5_cnt", b_if.stall_cycles, 10);
        chk("t5_err", 32'(b_if.mem_timeout_error), 1);

        // clear unit B before the timeout test
        reset = 1'b1;
        #1;
        chk("rst2_err_b", 32'(b_if.mem_timeout_error), 0);
        chk("rst2_cnt_b", b_if.stall_cycles, 0);
        tick();
        reset = 1'b0;
        #1;

        // T6: ready low for 5 cycles, timeout 3
        drive_b(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk($sformatf("t6_frz%0d", i), ctl_b(), FREEZE);
            tick();
            chk($sformatf("t6_err%0d", i),
                32'(b_if.mem_timeout_error), (i >= 3) ? 1 : 0);
        end
        chk("t6_cnt", b_if.stall_cycles, 5);
        reset = 1'b1;
        #1;
        chk("t6_rst_ctl", ctl_b(), RSTV);
        chk("t6_rst_err", 32'(b_if.mem_timeout_error), 0);
        chk("t6_rst_cnt", b_if.stall_cycles, 0);
        chk("t6_rst_fa", a_if.flush_count, 0);
        tick();
        reset = 1'b0;
        drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t6_run", ctl_b(), NORM);
        tick();
        chk("t6_err_post", 32'(b_if.mem_timeout_error), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
